// File: rtl/data_ram_ws_if.sv
// Data-port bundle between the CPU load/store unit and data_ram_ws.
// master: CPU side (drives ce/we/addr/sel/data_i);
// slave: RAM side (drives data_o/stallreq/ack/err).
interface data_ram_ws_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        stallreq;
    logic        ack;
    logic        err;

    modport master (
        output ce, we, addr, sel, data_i,
        input  data_o, stallreq, ack, err
    );

    modport slave (
        input  ce, we, addr, sel, data_i,
        output data_o, stallreq, ack, err
    );
endinterface

// File: rtl/data_ram_ws.sv
// Word-addressed, byte-lane writable data RAM with a programmable
// wait-state FSM (IDLE -> BUSY -> ACK) that stalls the pipeline.
// Ports: clk (rising edge), rst (sync, active low),
//        bus (data_ram_ws_if.slave: ce/we/addr/sel/data_i in,
//        data_o/stallreq/ack/err out).
// Optional macro DATA_RAM_RANGE_CHECK_EN: flag addresses above the
// array as errors (write dropped, read returns 0); otherwise they alias.
module data_ram_ws #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    data_ram_ws_if.slave  bus
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("data_ram_ws: WAIT_CYCLES must be 0..15");
    end
    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 29) begin : g_bad_depth
        $error("data_ram_ws: DEPTH_LOG2 must be 1..29");
    end

    localparam int WORDS = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [3:0]            cnt;
    logic                  wr_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [3:0]            sel_q;
    logic [31:0]           wdata_q;
    logic                  oor_q;
    logic [31:0]           rdata;
    logic                  oor;
    logic                  commit;

    logic [31:0] mem [0:WORDS-1];

    // Byte offset and (without range checking) upper bits carry no
    // meaning for this RAM.
    logic unused_addr;
    assign unused_addr = ^{bus.addr[1:0], bus.addr[31:DEPTH_LOG2+2]};

`ifdef DATA_RAM_RANGE_CHECK_EN
    assign oor = |(bus.addr >> (DEPTH_LOG2 + 2));
`else
    assign oor = 1'b0;
`endif

    assign commit = (state == BUSY) && (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.ce) state_nx = BUSY;
            BUSY:    if (cnt == 4'd0) state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request is captured once in IDLE and used for the whole access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            sel_q   <= 4'd0;
            wdata_q <= 32'd0;
            oor_q   <= 1'b0;
            rdata   <= 32'd0;
        end else begin
            if (state == IDLE && bus.ce) begin
                cnt     <= 4'(WAIT_CYCLES);
                wr_q    <= bus.we;
                idx_q   <= bus.addr[DEPTH_LOG2+1:2];
                sel_q   <= bus.sel;
                wdata_q <= bus.data_i;
                oor_q   <= oor;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit && !wr_q) begin
                rdata <= oor_q ? 32'd0 : mem[idx_q];
            end
        end
    end

    // Array is never cleared; rst gating drops a write whose commit
    // edge coincides with reset.
    always_ff @(posedge clk) begin
        if (rst && commit && wr_q && !oor_q) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign bus.data_o   = rdata;
    assign bus.stallreq = bus.ce && (state != ACK);
    assign bus.ack      = (state == ACK);

`ifdef DATA_RAM_RANGE_CHECK_EN
    assign bus.err = (state == ACK) && oor_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_data_ram_ws.sv
// Directed bench for data_ram_ws: two instances (2 and 0 wait states),
// read data checked against a scoreboard queue at each ack.
module tb_data_ram_ws;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    data_ram_ws_if b0 ();
    data_ram_ws_if b1 ();

    data_ram_ws #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    data_ram_ws #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    logic [31:0] last_rd [2];

    int ack_cyc;
    int stalls;
    bit err_s;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(input bit d, input bit ce,
                         input bit w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] dat);
        b0.we = w; b0.addr = a; b0.sel = s; b0.data_i = dat;
        b1.we = w; b1.addr = a; b1.sel = s; b1.data_i = dat;
        b0.ce = ce && !d;
        b1.ce = ce && d;
    endtask

    // Starts at posedge+1 (cycle 0), ends at posedge+1 after the ack
    // cycle with ce low, so back-to-back calls issue right after ACK.
    task automatic access(input bit d, input bit w,
                          input logic [31:0] a,
                          input logic [3:0] s,
                          input logic [31:0] dat,
                          input int drop_at,
                          input string tag);
        logic [31:0] exp_d;
        drive(d, 1'b1, w, a, s, dat);
        ack_cyc = -1;
        stalls  = 0;
        err_s   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k >= 1) begin
                // latched request must ignore later bus changes
                b0.addr = ~a; b1.addr = ~a;
                b0.data_i = ~dat; b1.data_i = ~dat;
            end
            if (k == drop_at) begin
                b0.ce = 1'b0; b1.ce = 1'b0;
            end
            @(negedge clk);
            if (d ? b1.stallreq : b0.stallreq) stalls++;
            if (d ? b1.ack : b0.ack) begin
                ack_cyc = k;
                err_s   = d ? b1.err : b0.err;
                break;
            end
            @(posedge clk); #1;
        end
        if (ack_cyc < 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else if (!w) begin
            if (exp_q.size() == 0) begin
                check({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                exp_d = exp_q.pop_front();
                check({tag, "_rdata"},
                      d ? b1.data_o : b0.data_o, exp_d);
                last_rd[d] = exp_d;
            end
        end else begin
            check({tag, "_hold"},
                  d ? b1.data_o : b0.data_o, last_rd[d]);
        end
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_data_o", b0.data_o, 32'd0);
        check("rst_ack", {31'd0, b0.ack}, 32'd0);
        check("rst_err", {31'd0, b0.err}, 32'd0);
        check("rst_stall", {31'd0, b0.stallreq}, 32'd0);
        @(posedge clk); #1;

        // full-word write then read, 2 wait states
        access(0, 1, 32'h40, 4'hF, 32'h12345678, -1, "t1_wr");
        check("t1_wr_ackcyc", 32'(ack_cyc), 32'd4);
        check("t1_wr_stalls", 32'(stalls), 32'd4);
        exp_q.push_back(32'h12345678);
        access(0, 0, 32'h40, 4'hF, 32'h0, -1, "t1_rd");
        check("t1_rd_ackcyc", 32'(ack_cyc), 32'd4);
        check("t1_rd_stalls", 32'(stalls), 32'd4);

        // single byte lane write merges into existing word
        access(0, 1, 32'h40, 4'b0010, 32'h0000AB00, -1, "t2_wr");
        exp_q.push_back(32'h1234AB78);
        access(0, 0, 32'h43, 4'h0, 32'h0, -1, "t2_rd");

        // sel=0000 write leaves memory untouched
        access(0, 1, 32'h40, 4'h0, 32'hFFFFFFFF, -1, "t2_nosel");
        check("t2_nosel_ackcyc", 32'(ack_cyc), 32'd4);
        exp_q.push_back(32'h1234AB78);
        access(0, 0, 32'h40, 4'hF, 32'h0, -1, "t2_rd2");

        // zero wait states, back-to-back reads
        access(1, 1, 32'h10, 4'hF, 32'hA5A50F0F, -1, "t3_wr");
        check("t3_wr_ackcyc", 32'(ack_cyc), 32'd2);
        exp_q.push_back(32'hA5A50F0F);
        access(1, 0, 32'h10, 4'hF, 32'h0, -1, "t3_rd1");
        check("t3_rd1_ackcyc", 32'(ack_cyc), 32'd2);
        check("t3_rd1_stalls", 32'(stalls), 32'd2);
        exp_q.push_back(32'hA5A50F0F);
        access(1, 0, 32'h10, 4'hF, 32'h0, -1, "t3_rd2");
        check("t3_rd2_ackcyc", 32'(ack_cyc), 32'd2);
        check("t3_rd2_stalls", 32'(stalls), 32'd2);

        // reset on the commit edge of a write drops the write
        access(0, 1, 32'h80, 4'hF, 32'hCAFEF00D, -1, "t4_pre");
        drive(0, 1'b1, 1'b1, 32'h80, 4'hF, 32'hDEADBEEF);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("t4_ack", {31'd0, b0.ack}, 32'd0);
        check("t4_data_o", b0.data_o, 32'd0);
        check("t4_state", {30'd0, u0.state}, 32'd0);
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        @(posedge clk); #1;
        exp_q.push_back(32'hCAFEF00D);
        access(0, 0, 32'h80, 4'hF, 32'h0, -1, "t4_rd");
        check("t4_rd_ackcyc", 32'(ack_cyc), 32'd4);

        // ce dropped during BUSY
        access(0, 1, 32'h44, 4'hF, 32'h0BADF00D, -1, "t5_wr");
        exp_q.push_back(32'h0BADF00D);
        access(0, 0, 32'h44, 4'hF, 32'h0, 1, "t5_rd");
        check("t5_ackcyc", 32'(ack_cyc), 32'd4);
        check("t5_stalls", 32'(stalls), 32'd1);

        // out-of-range address
        access(0, 1, 32'h0, 4'hF, 32'h11111111, -1, "t6_init");
        check("t6_init_err", {31'd0, err_s}, 32'd0);
        access(0, 1, 32'h1000, 4'hF, 32'h99999999, -1, "t6_wr");
        check("t6_wr_ackcyc", 32'(ack_cyc), 32'd4);
`ifdef DATA_RAM_RANGE_CHECK_EN
        check("t6_wr_err", {31'd0, err_s}, 32'd1);
        exp_q.push_back(32'h11111111);
        access(0, 0, 32'h0, 4'hF, 32'h0, -1, "t6_rd0");
        exp_q.push_back(32'h0);
        access(0, 0, 32'h1000, 4'hF, 32'h0, -1, "t6_rdoor");
        check("t6_rdoor_err", {31'd0, err_s}, 32'd1);
`else
        check("t6_wr_err", {31'd0, err_s}, 32'd0);
        exp_q.push_back(32'h99999999);
        access(0, 0, 32'h0, 4'hF, 32'h0, -1, "t6_rd0");
        check("t6_rd0_err", {31'd0, err_s}, 32'd0);
`endif

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
